if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction fetch front end: owns the PC and issues in-order 32-bit reads to instruction memory.
//  Buffers returned instructions, with their PCs, in a small fetch queue that drains to decode.
//  Accepts the branch/jump redirect (i_do_branch, i_bt) produced by the execute stage.
//  On redirect it flushes the queue and discards responses still in flight.
// PARAMETERS
//  RESET_PC         64'h0  PC of first fetch after reset
//  FQ_DEPTH         4      fetch queue entries (power of 2, >=2)
//  MAX_OUTSTANDING  2      max imem requests accepted but not yet answered (>=1, <=FQ_DEPTH)
// PORTS
//  i_clk            in   1   clock, all state on rising edge
//  i_rst            in   1   synchronous active-high reset
//  o_imem_req_valid out  1   fetch request valid
//  i_imem_req_ready in   1   imem accepts request this cycle
//  o_imem_addr      out  64  fetch address, bits[1:0]=0
//  i_imem_rsp_valid in   1   read data valid; in order; no back-pressure
//  i_imem_rsp_data  in   32  instruction word
//  i_do_branch      in   1   redirect from execute stage, single-cycle pulse
//  i_bt             in   64  redirect target, bits[1:0] ignored (treated as 0)
//  o_if_valid       out  1   queue head valid to decode
//  o_if_pc          out  64  PC of head instruction
//  o_if_inst        out  32  head instruction
//  i_id_ready       in   1   decode accepts head this cycle
// BEHAVIOUR
//  Reset (i_rst=1 at edge):
//   - fetch_pc <= RESET_PC; rsp_pc <= RESET_PC.
//   - outstanding, drop_cnt and queue count <= 0.
//   - o_imem_req_valid=0 and o_if_valid=0 while i_rst=1 (combinational gating).
//   - Reset mid-operation discards everything. Later responses to pre-reset requests are the integrator's responsibility; imem is reset with the core.
//  Request:
//   - o_imem_req_valid = !i_rst && !i_do_branch && outstanding<MAX_OUTSTANDING && outstanding+fq_count<FQ_DEPTH.
//   - Credit uses registered counts only; no comb path from i_id_ready or rsp_valid to req_valid.
//   - o_imem_addr=fetch_pc. Addr is held stable while valid and not ready.
//   - Handshake on valid&&ready: fetch_pc += 4; outstanding += 1.
//  Response (i_imem_rsp_valid):
//   - outstanding -= 1.
//   - If drop_cnt>0: data discarded; drop_cnt -= 1.
//   - Else: {rsp_pc, data} pushed to queue tail; rsp_pc += 4.
//   - Overflow is impossible by credit rule; assert: push never while full.
//  Decode side:
//   - o_if_valid = fq_count!=0 && !i_do_branch; o_if_pc/o_if_inst = head entry.
//   - Pop on o_if_valid&&i_id_ready. Push and pop in the same cycle keep the count unchanged.
//   - No queue bypass: minimum latency is req accept at cycle N, rsp at N+1, o_if_valid at N+2.
//  Redirect (i_do_branch=1 at edge), priority over normal update:
//   - fetch_pc <= {i_bt[63:2],2'b0}; rsp_pc <= same.
//   - Queue cleared.
//   - drop_cnt <= outstanding - (i_imem_rsp_valid?1:0), i.e. all still-in-flight requests are dropped.
//   - A response arriving in the redirect cycle is discarded. No request is issued in the redirect cycle.
//   - First target request is eligible the next cycle.
//   - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
//  Arithmetic:
//   - 64-bit PC increments wrap modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC+4 -> 0).
//   - Counters are sized to hold 0..FQ_DEPTH without overflow.
// TESTING
//  1 Reset, RESET_PC=0x1000, imem 1-cycle latency, i_id_ready=1 -> requests 0x1000,0x1004,...; decode sees pc 0x1000 first, 2 cycles after first accept.
//  2 i_id_ready=0 -> queue fills 4 entries, then o_imem_req_valid=0; raise ready -> drains 0x1000..0x100C in order, fetching resumes.
//  3 i_imem_req_ready=0 for 5 cycles -> o_imem_addr stays 0x1000, valid held, fetch_pc unchanged.
//  4 imem 3-cycle latency, 2 in flight, i_do_branch with i_bt=0x2002 -> both old rsps dropped; next req 0x2000; decode next sees pc 0x2000.
//  5 Redirect in the same cycle as a response -> that response dropped, drop_cnt=outstanding-1, no wrong-path instruction reaches decode.
//  6 i_rst pulsed with queue full and requests in flight -> outputs low that cycle, queue empty; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order imem reads under a credit limit,
// buffers {pc, inst} in a small queue to decode, and squashes in-flight work on redirect.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          FQ_DEPTH        = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_do_branch,
  input  logic [63:0] i_bt,
  output logic        o_if_valid,
  output logic [63:0] o_if_pc,
  output logic [31:0] o_if_inst,
  input  logic        i_id_ready
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW-1:0] MAX_OS  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] FQ_FULL = CW'(FQ_DEPTH);
  localparam logic [CW:0]   DEPTH   = (CW+1)'(FQ_DEPTH);

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] os_cnt_q, os_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fq_cnt_q, fq_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [63:0]   fq_pc_q   [FQ_DEPTH];
  logic [31:0]   fq_inst_q [FQ_DEPTH];

  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [63:0]   bt_aligned;

  // Credit looks only at registered counts, so decode/response timing never reaches req_valid.
  assign credit_sum = {1'b0, os_cnt_q} + {1'b0, fq_cnt_q};
  assign credit_ok  = (os_cnt_q < MAX_OS) && (credit_sum < DEPTH);
  assign bt_aligned = i_bt & ~64'h3;

  assign o_imem_req_valid = !i_rst && !i_do_branch && credit_ok;
  assign o_imem_addr      = fetch_pc_q;
  assign o_if_valid       = !i_rst && !i_do_branch && (fq_cnt_q != '0);
  assign o_if_pc          = fq_pc_q[rd_ptr_q];
  assign o_if_inst        = fq_inst_q[rd_ptr_q];

  assign req_fire = o_imem_req_valid && i_imem_req_ready;
  assign push     = i_imem_rsp_valid && (drop_cnt_q == '0) && !i_do_branch;
  assign pop      = o_if_valid && i_id_ready;

  always_comb begin
    fetch_pc_d = req_fire ? fetch_pc_q + 64'd4 : fetch_pc_q;
    rsp_pc_d   = push ? rsp_pc_q + 64'd4 : rsp_pc_q;
    os_cnt_d   = os_cnt_q + CW'(req_fire) - CW'(i_imem_rsp_valid);
    drop_cnt_d = (i_imem_rsp_valid && (drop_cnt_q != '0)) ? drop_cnt_q - CW'(1) : drop_cnt_q;
    fq_cnt_d   = fq_cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    // Redirect: every request still in flight after this edge belongs to the old path.
    if (i_do_branch) begin
      fetch_pc_d = bt_aligned;
      rsp_pc_d   = bt_aligned;
      drop_cnt_d = os_cnt_q - CW'(i_imem_rsp_valid);
      fq_cnt_d   = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      os_cnt_q   <= '0;
      drop_cnt_q <= '0;
      fq_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      os_cnt_q   <= os_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fq_cnt_q   <= fq_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Queue storage holds data only; validity comes from fq_cnt_q.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fq_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fq_inst_q[wr_ptr_q] <= i_imem_rsp_data;
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(push && (fq_cnt_q == FQ_FULL)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: cycle table for fetch/backpressure/stall, then hand
// sequences for redirect, redirect-with-response, PC wrap and mid-run reset.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready = 1'b1;
  logic [63:0] addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        do_branch = 1'b0;
  logic [63:0] bt = '0;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready = 1'b1;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(64'h1000), .FQ_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_addr(addr),
    .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
    .i_do_branch(do_branch), .i_bt(bt),
    .o_if_valid(if_valid), .o_if_pc(if_pc), .o_if_inst(if_inst), .i_id_ready(id_ready)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct { logic [63:0] a; int due; } mreq_t;
  mreq_t       mq[$];
  logic [63:0] req_log[$];
  logic [63:0] dec_pc_log[$];
  logic [31:0] dec_inst_log[$];

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_BEEF;
  endfunction

  // imem model: in-order, fixed latency, reset together with the core
  always @(posedge clk) begin
    cyc++;
    if (rst) mq.delete();
    else begin
      if (rsp_valid && mq.size() > 0) void'(mq.pop_front());
      if (req_valid && req_ready) begin
        mq.push_back('{a: addr, due: cyc + lat});
        req_log.push_back(addr);
      end
      if (if_valid && id_ready) begin
        dec_pc_log.push_back(if_pc);
        dec_inst_log.push_back(if_inst);
      end
    end
  end

  always @(negedge clk) begin
    if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
      rsp_valid = 1'b1;
      rsp_data  = inst_of(mq[0].a);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_dec(input string nm, input int idx, input logic [63:0] exp_pc);
    if (idx < dec_pc_log.size()) begin
      chk({nm, " pc"}, dec_pc_log[idx], exp_pc);
      chk({nm, " inst"}, {32'h0, dec_inst_log[idx]}, {32'h0, inst_of(exp_pc)});
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL %s: decode entry %0d missing (have %0d)", nm, idx, dec_pc_log.size());
    end
  endtask

  task automatic chk_req(input string nm, input int idx, input logic [63:0] exp_a);
    if (idx < req_log.size()) chk(nm, req_log[idx], exp_a);
    else begin
      n_cmp++; n_fail++;
      $display("FAIL %s: request %0d missing (have %0d)", nm, idx, req_log.size());
    end
  endtask

  // Drive one cycle's inputs on the falling edge; outputs are settled 1 time unit later.
  task automatic step(input logic r, input logic idr, input logic rr, input logic br,
                      input logic [63:0] t);
    @(negedge clk);
    rst = r; id_ready = idr; req_ready = rr; do_branch = br; bt = t;
    #1;
  endtask

  typedef struct {
    logic rst, idr, rr;
    logic e_req; logic [63:0] e_addr;
    logic e_if;  logic [63:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic idr, input logic rr, input logic er,
                              input logic [63:0] ea, input logic ei, input logic [63:0] ep);
    vec_t v;
    v.rst = r; v.idr = idr; v.rr = rr; v.e_req = er; v.e_addr = ea; v.e_if = ei; v.e_pc = ep;
    return v;
  endfunction

  vec_t vec[26];
  int   nr, nd;

  initial begin
    // 1-cycle imem; rows 0-5 steady fetch, 6-17 decode stall then drain, 18-25 imem stall
    vec[0]  = mk(1,1,1, 0,64'h0,    0,64'h0);
    vec[1]  = mk(0,1,1, 1,64'h1000, 0,64'h0);
    vec[2]  = mk(0,1,1, 1,64'h1004, 0,64'h0);
    vec[3]  = mk(0,1,1, 1,64'h1008, 1,64'h1000);
    vec[4]  = mk(0,1,1, 1,64'h100C, 1,64'h1004);
    vec[5]  = mk(0,1,1, 1,64'h1010, 1,64'h1008);
    vec[6]  = mk(1,0,1, 0,64'h0,    0,64'h0);
    vec[7]  = mk(0,0,1, 1,64'h1000, 0,64'h0);
    vec[8]  = mk(0,0,1, 1,64'h1004, 0,64'h0);
    vec[9]  = mk(0,0,1, 1,64'h1008, 1,64'h1000);
    vec[10] = mk(0,0,1, 1,64'h100C, 1,64'h1000);
    vec[11] = mk(0,0,1, 0,64'h0,    1,64'h1000);
    vec[12] = mk(0,0,1, 0,64'h0,    1,64'h1000);
    vec[13] = mk(0,1,1, 0,64'h0,    1,64'h1000);
    vec[14] = mk(0,1,1, 1,64'h1010, 1,64'h1004);
    vec[15] = mk(0,1,1, 1,64'h1014, 1,64'h1008);
    vec[16] = mk(0,1,1, 1,64'h1018, 1,64'h100C);
    vec[17] = mk(0,1,1, 1,64'h101C, 1,64'h1010);
    vec[18] = mk(0,1,0, 1,64'h1020, 1,64'h1014);
    vec[19] = mk(0,1,0, 1,64'h1020, 1,64'h1018);
    vec[20] = mk(0,1,0, 1,64'h1020, 1,64'h101C);
    vec[21] = mk(0,1,0, 1,64'h1020, 0,64'h0);
    vec[22] = mk(0,1,0, 1,64'h1020, 0,64'h0);
    vec[23] = mk(0,1,1, 1,64'h1020, 0,64'h0);
    vec[24] = mk(0,1,1, 1,64'h1024, 0,64'h0);
    vec[25] = mk(0,1,1, 1,64'h1028, 1,64'h1020);

    for (int i = 0; i < 26; i++) begin
      step(vec[i].rst, vec[i].idr, vec[i].rr, 1'b0, 64'h0);
      chk($sformatf("row%0d req_valid", i), {63'h0, req_valid}, {63'h0, vec[i].e_req});
      if (vec[i].e_req) chk($sformatf("row%0d addr", i), addr, vec[i].e_addr);
      chk($sformatf("row%0d if_valid", i), {63'h0, if_valid}, {63'h0, vec[i].e_if});
      if (vec[i].e_if) begin
        chk($sformatf("row%0d if_pc", i), if_pc, vec[i].e_pc);
        chk($sformatf("row%0d if_inst", i), {32'h0, if_inst}, {32'h0, inst_of(vec[i].e_pc)});
      end
    end

    // Redirect with two requests in flight, 3-cycle imem
    lat = 3;
    step(1,1,1,0,64'h0);
    step(0,1,1,0,64'h0);
    step(0,1,1,0,64'h0);
    step(0,1,1,1,64'h2002);
    chk("t4 branch req_valid", {63'h0, req_valid}, 64'h0);
    nr = req_log.size(); nd = dec_pc_log.size();
    step(0,1,1,0,64'h0);
    chk("t4 draining req_valid", {63'h0, req_valid}, 64'h0);
    repeat (10) step(0,1,1,0,64'h0);
    chk_req("t4 first req", nr, 64'h2000);
    chk_dec("t4 dec0", nd, 64'h2000);
    chk_dec("t4 dec1", nd + 1, 64'h2004);

    // Redirect coinciding with a response, 2-cycle imem
    lat = 2;
    step(1,1,1,0,64'h0);
    step(0,1,1,0,64'h0);
    step(0,1,1,0,64'h0);
    step(0,1,1,1,64'h3000);
    nr = req_log.size(); nd = dec_pc_log.size();
    repeat (10) step(0,1,1,0,64'h0);
    chk_req("t5 first req", nr, 64'h3000);
    chk_dec("t5 dec0", nd, 64'h3000);
    chk_dec("t5 dec1", nd + 1, 64'h3004);

    // Redirect with credit and queue available, to a target that wraps the PC
    lat = 1;
    step(1,1,1,0,64'h0);
    repeat (4) step(0,1,1,0,64'h0);
    step(0,1,1,1,64'hFFFF_FFFF_FFFF_FFFB);
    chk("wrap branch req_valid", {63'h0, req_valid}, 64'h0);
    chk("wrap branch if_valid", {63'h0, if_valid}, 64'h0);
    nr = req_log.size(); nd = dec_pc_log.size();
    repeat (8) step(0,1,1,0,64'h0);
    chk_req("wrap req0", nr, 64'hFFFF_FFFF_FFFF_FFF8);
    chk_req("wrap req1", nr + 1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk_req("wrap req2", nr + 2, 64'h0);
    chk_dec("wrap dec0", nd, 64'hFFFF_FFFF_FFFF_FFF8);
    chk_dec("wrap dec1", nd + 1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk_dec("wrap dec2", nd + 2, 64'h0);

    // Reset with a partly full queue and a request in flight
    step(1,0,1,0,64'h0);
    repeat (4) step(0,0,1,0,64'h0);
    step(1,1,1,0,64'h0);
    chk("t6 rst req_valid", {63'h0, req_valid}, 64'h0);
    chk("t6 rst if_valid", {63'h0, if_valid}, 64'h0);
    nd = dec_pc_log.size();
    step(0,1,1,0,64'h0);
    chk("t6 post if_valid", {63'h0, if_valid}, 64'h0);
    chk("t6 post req_valid", {63'h0, req_valid}, 64'h1);
    chk("t6 post addr", addr, 64'h1000);
    repeat (4) step(0,1,1,0,64'h0);
    chk_dec("t6 dec0", nd, 64'h1000);
    chk_dec("t6 dec1", nd + 1, 64'h1004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
